// File: rtl/ft_tx_framer_pkg.sv
// ft_pkg: shared constants and framer state encoding for the FT600 TX path.
package ft_pkg;
  localparam logic [7:0] FT_SYNC_DEFAULT = 8'hA5;
  localparam logic [7:0] FT_CRC8_POLY = 8'h07;
  typedef enum logic [2:0] {IDLE, SYNC, LEN, PAYLOAD, CHK} ft_state_e;
endpackage

// File: rtl/ft_tx_framer_crc8.sv
// ft_crc8_byte: combinational CRC-8 update (MSB first, unreflected) for one data byte.
module ft_crc8_byte
  import ft_pkg::*;
(
  input  logic [7:0] crc,
  input  logic [7:0] data,
  output logic [7:0] nxt
);
  logic [7:0] c;
  always_comb begin
    c = crc ^ data;
    for (int i = 0; i < 8; i++) c = {c[6:0], 1'b0} ^ (c[7] ? FT_CRC8_POLY : 8'h00);
    nxt = c;
  end
endmodule

// File: rtl/ft_tx_framer.sv
// ft_tx_framer: wraps payloads as SYNC,LEN,payload,CHK into the FT600 TX FIFO, paced by tx_full.
// Define FT_TX_FRAMER_CRC8_EN for a CRC-8 check byte; otherwise the check is the two's-complement sum.
module ft_tx_framer
  import ft_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = FT_SYNC_DEFAULT,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic [7:0]           req_len,
  output logic                 req_ready,
  input  logic                 s_valid,
  input  logic [7:0]           s_data,
  output logic                 s_ready,
  output logic                 tx_en,
  output logic [7:0]           tx_in,
  input  logic                 tx_full,
  output logic                 busy,
  output logic                 frame_done,
  output logic [CNT_WIDTH-1:0] frame_cnt
);
  ft_state_e state, state_n;
  logic [7:0] len_r, rem_r, chk_r, chk_nxt;
  // chk_r always holds the byte to emit in CHK, so the sum mode accumulates the negated sum
`ifdef FT_TX_FRAMER_CRC8_EN
  ft_crc8_byte u_crc (.crc(chk_r), .data(tx_in), .nxt(chk_nxt));
`else
  assign chk_nxt = chk_r - tx_in;
`endif
  always_comb begin
    req_ready = state == IDLE;
    busy = state != IDLE;
    s_ready = (state == PAYLOAD) & ~tx_full;
    tx_en = ~tx_full & ((state == SYNC) | (state == LEN) | (state == CHK) | ((state == PAYLOAD) & s_valid));
    tx_in = state == SYNC ? SYNC_BYTE : state == LEN ? len_r : state == PAYLOAD ? s_data :
            state == CHK ? chk_r : 8'h00;
    state_n = state;
    if (state == IDLE && req_valid) state_n = SYNC;
    else if (tx_en)
      state_n = state == SYNC ? LEN :
                state == LEN ? (len_r == 8'd0 ? CHK : PAYLOAD) :
                state == PAYLOAD ? (rem_r == 8'd1 ? CHK : PAYLOAD) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      len_r <= '0;
      rem_r <= '0;
      chk_r <= '0;
      frame_done <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state <= state_n;
      frame_done <= tx_en & (state == CHK);
      if (tx_en && state == CHK) frame_cnt <= frame_cnt + CNT_WIDTH'(1);
      if (state == IDLE && req_valid) begin
        len_r <= req_len;
        rem_r <= req_len;
        chk_r <= '0;
      end
      if (tx_en && (state == LEN || state == PAYLOAD)) chk_r <= chk_nxt;
      if (tx_en && state == PAYLOAD) rem_r <= rem_r - 8'd1;
    end
  end
endmodule

// File: tb/tb_ft_tx_framer.sv
// tb_ft_tx_framer: directed scoreboard bench; expected bytes queued per request, popped on tx_en.
module tb_ft_tx_framer;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, s_valid = 1'b0, tx_full = 1'b0;
  logic [7:0] req_len = '0, s_data = '0;
  logic req_ready, s_ready, tx_en, busy, frame_done;
  logic [7:0] tx_in;
  logic [15:0] frame_cnt;
  int total = 0, bad = 0;
  logic [7:0] exp_q[$], src_q[$];
  logic [15:0] cnt_exp = '0;

  always #5 clk = ~clk;

  ft_tx_framer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_len(req_len), .req_ready(req_ready),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .tx_en(tx_en), .tx_in(tx_in),
    .tx_full(tx_full), .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] crc_step(input logic [7:0] c_in, input logic [7:0] d);
    logic [7:0] c;
    logic fb;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  function automatic logic [7:0] model_chk(input logic [7:0] len);
    logic [7:0] c;
`ifdef FT_TX_FRAMER_CRC8_EN
    c = crc_step(8'h00, len);
    foreach (src_q[i]) c = crc_step(c, src_q[i]);
`else
    c = len;
    foreach (src_q[i]) c = c + src_q[i];
    c = 8'h00 - c;
`endif
    return c;
  endfunction

  task automatic frame(input int len, input bit gaps, input int full_at, input int abort_at, input string tag);
    int taken = 0, cyc = 0, hs = -1, full_left = 0;
    bit req_done = 0, full_trig = 0, done = 0, sready_seen = 0, hs_now, sv_now;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(len));
    foreach (src_q[i]) exp_q.push_back(src_q[i]);
    exp_q.push_back(model_chk(8'(len)));
    @(negedge clk);
    while (cyc < 700) begin
      if (abort_at >= 0 && taken == abort_at) begin
        rst = 1'b1;
        req_valid = 1'b0;
        s_valid = 1'b0;
        #1;
        check({tag, "_abort_tx_en"}, tx_en, 0);
        check({tag, "_abort_busy"}, busy, 0);
        check({tag, "_abort_done"}, frame_done, 0);
        check({tag, "_abort_cnt"}, frame_cnt, cnt_exp);
        check({tag, "_abort_req_ready"}, req_ready, 1);
        exp_q.delete();
        src_q.delete();
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      req_valid = !req_done;
      req_len = 8'(len);
      if (!full_trig && full_at >= 0 && taken == full_at) begin
        full_trig = 1;
        full_left = 3;
      end
      tx_full = full_left > 0;
      if (full_left > 0) full_left--;
      s_valid = src_q.size() > 0 && (!gaps || cyc[0]);
      s_data = src_q.size() > 0 ? src_q[0] : 8'h00;
      #1;
      if (s_ready) sready_seen = 1;
      if (tx_full) check({tag, "_full_blocks"}, {tx_en, s_ready}, 0);
      if (tx_en) begin
        if (exp_q.size() > 0) check({tag, "_tx_byte"}, tx_in, exp_q.pop_front());
        else check({tag, "_tx_extra"}, exp_q.size(), 1);
      end
      if (frame_done) begin
        done = 1;
        cnt_exp++;
        check({tag, "_frame_cnt"}, frame_cnt, cnt_exp);
        if (!gaps && full_at < 0) check({tag, "_latency"}, cyc - hs, len + 4);
        break;
      end
      hs_now = req_valid & req_ready;
      sv_now = s_valid & s_ready;
      @(posedge clk);
      if (hs_now) begin
        req_done = 1;
        hs = cyc;
      end
      if (sv_now) begin
        void'(src_q.pop_front());
        taken++;
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_bytes_left"}, exp_q.size(), 0);
    if (len == 0) check({tag, "_zero_sready"}, sready_seen, 0);
    req_valid = 1'b0;
    s_valid = 1'b0;
    tx_full = 1'b0;
    @(negedge clk);
    #1;
    check({tag, "_done_pulse_len"}, frame_done, 0);
    check({tag, "_idle_req_ready"}, req_ready, 1);
    check({tag, "_cnt_hold"}, frame_cnt, cnt_exp);
    exp_q.delete();
    src_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_tx_en", tx_en, 0);
    check("rst_tx_in", tx_in, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    src_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    frame(4, 0, -1, 2, "abort");
    src_q = '{8'h01, 8'h02};
    frame(2, 0, -1, -1, "basic");
    frame(0, 0, -1, -1, "zero");
    src_q = '{8'h05, 8'h06, 8'h07, 8'h08};
    frame(4, 0, 1, -1, "backpressure");
    src_q = '{8'h10, 8'h20, 8'h30, 8'h40};
    frame(4, 1, -1, -1, "gaps");
    src_q = '{8'hFF};
    frame(1, 0, -1, -1, "one");
    for (int k = 0; k < 255; k++) src_q.push_back(8'($urandom_range(0, 255)));
    frame(255, 0, -1, -1, "max_len");
    for (int n = 0; n < 3; n++) begin
      int l;
      l = $urandom_range(1, 20);
      for (int k = 0; k < l; k++) src_q.push_back(8'($urandom_range(0, 255)));
      frame(l, n[0], (n == 2) ? 2 : -1, -1, "rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
